audio_sample_sink: RTL



---
 rtl/audio_sample_sink.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/audio_sample_sink.sv
// Consumer end of the sample-rate audio interface: strobed capture into a show-ahead FIFO,
// valid/ready output, overflow counting, silence detection. Optional peak meter: AUDIO_SINK_PEAK_EN.
module audio_sample_sink #(
    parameter int DEPTH             = 8,
    parameter int SILENCE_THRESHOLD = 64,
    parameter int SILENCE_SAMPLES   = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   audio_clk_en,
    input  logic [15:0]            sample_in,
    output logic [15:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            overflow_count,
`ifdef AUDIO_SINK_PEAK_EN
    input  logic                   peak_clear,
    output logic [14:0]            peak,
`endif
    output logic                   silence
);

    localparam int                 PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_LEVEL = (PTR_W + 1)'(DEPTH);
    localparam logic [15:0]        QUIET_MAX  = 16'(SILENCE_SAMPLES);
    localparam logic [31:0]        QUIET_THR  = 32'(SILENCE_THRESHOLD);

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    logic [15:0]      neg_sample;
    logic [14:0]      sample_abs;
    logic             is_quiet;
    logic [15:0]      quiet_cnt;
    logic [15:0]      quiet_next;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign full      = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    assign do_pop    = out_valid && out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign do_push   = audio_clk_en && (!full || do_pop);
    assign drop      = audio_clk_en && full && !do_pop;

    // Show-ahead: the head entry is read straight from the storage array.
    assign out_data  = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_count <= '0;
        end else if (drop && (overflow_count != 16'hFFFF)) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Magnitude and silence detection
    // ------------------------------------------------------------------
    assign neg_sample = 16'd0 - sample_in;

    // -32768 has no positive counterpart in 16 bits, so it saturates to 32767.
    always_comb begin
        sample_abs = sample_in[14:0];
        if (sample_in == 16'h8000) begin
            sample_abs = 15'h7FFF;
        end else if (sample_in[15]) begin
            sample_abs = neg_sample[14:0];
        end
    end

    assign is_quiet = (32'(sample_abs) <= QUIET_THR);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        quiet_next = '0;
        if (is_quiet) begin
            quiet_next = (quiet_cnt == QUIET_MAX) ? quiet_cnt : quiet_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quiet_cnt <= '0;
            silence   <= 1'b0;
        end else if (audio_clk_en) begin
            quiet_cnt <= quiet_next;
            silence   <= (quiet_next == QUIET_MAX);
        end
    end

`ifdef AUDIO_SINK_PEAK_EN
    // ------------------------------------------------------------------
    // Peak meter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            peak <= '0;
        end else if (peak_clear) begin
            peak <= audio_clk_en ? sample_abs : 15'd0;
        end else if (audio_clk_en && (sample_abs > peak)) begin
            peak <= sample_abs;
        end
    end
`endif

endmodule
